mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/mem_arb_pick.sv | 16 +
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_arb_pkg;

  // Bus widths of the block-read / word-write memory interface.
  localparam int ADDR_W  = 32;
  localparam int WORD_W  = 64;
  localparam int BLOCK_W = 128;

  // Encoding of the last-served requester.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Bit positions inside the request / one-hot grant vectors.
  localparam int REQ_I_BIT = 0;
  localparam int REQ_D_BIT = 1;
  localparam int NUM_REQ   = 2;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Maps a requester bit position to its last_grant encoding.
  function automatic logic side_of_bit(input int bit_idx);
    return (bit_idx == REQ_D_BIT) ? GRANT_D : GRANT_I;
  endfunction

  // Maps a one-hot grant vector to its last_grant encoding.
  function automatic logic side_of_grant(input logic [NUM_REQ-1:0] grant);
    return grant[REQ_D_BIT] ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way round-robin picker producing a one-hot grant.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant
);

  // A requester wins when it is alone, or on a tie when it was not served last.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pick
    localparam logic SIDE = side_of_bit(gi);
    assign grant[gi] = req[gi] & (~req[NUM_REQ-1-gi] | (last_grant != SIDE));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between the I-side refill path and
// the data cache. One transaction in flight; memory outputs come straight
// from registers latched on the grant edge.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_block_read_data,
  output logic               i_ready,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [WORD_W-1:0]  d_write_data,
  output logic [BLOCK_W-1:0] d_block_read_data,
  output logic               d_ready,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [WORD_W-1:0]  mem_write_data,
  output logic               mem_read_out,
  output logic               mem_write_out,
  input  logic [BLOCK_W-1:0] mem_block_read_data,
  input  logic               mem_ready,
  output logic               err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_t         state_reg;
  arb_state_t         state_next;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic               busy;
  logic               last_grant_reg;
  logic               op_write_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [WORD_W-1:0]  wdata_reg;
  logic [BLOCK_W-1:0] i_data_reg;
  logic [BLOCK_W-1:0] d_data_reg;
  logic [CNT_W-1:0]   wait_cnt_reg;
  logic               err_reg;

  // The D side asks for the port whether it wants a read or a write.
  assign req[REQ_I_BIT] = i_req;
  assign req[REQ_D_BIT] = d_read | d_write;

  mem_arb_pick u_pick (
    .req        (req),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  // Requests only matter in IDLE; during BUSY/RESP they are ignored.
  assign grant_any = (state_reg == IDLE) && (grant != '0);
  assign busy      = (state_reg == BUSY_I) || (state_reg == BUSY_D);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: grant, wait for memory, one response cycle, back to idle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant[REQ_D_BIT]) begin
          state_next = BUSY_D;
        end else if (grant[REQ_I_BIT]) begin
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: strobes while busy, ready pulse to the winner in RESP.
  always_comb begin
    mem_read_out  = 1'b0;
    mem_write_out = 1'b0;
    i_ready       = 1'b0;
    d_ready       = 1'b0;
    case (state_reg)
      BUSY_I, BUSY_D: begin
        mem_read_out  = ~op_write_reg;
        mem_write_out = op_write_reg;
      end
      RESP: begin
        i_ready = (last_grant_reg == GRANT_I);
        d_ready = (last_grant_reg == GRANT_D);
      end
      default: ;
    endcase
  end

  // Capture the winner's command on the grant edge; a D write beats a D read.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= GRANT_I;
      op_write_reg   <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else if (grant_any) begin
      last_grant_reg <= side_of_grant(grant);
      if (grant[REQ_D_BIT]) begin
        op_write_reg <= d_write;
        addr_reg     <= d_address;
        wdata_reg    <= d_write_data;
      end else begin
        op_write_reg <= 1'b0;
        addr_reg     <= i_address;
        wdata_reg    <= '0;
      end
    end
  end

  // Return block data to the winner; a write completion leaves D data untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_data_reg <= '0;
      d_data_reg <= '0;
    end else if (busy && mem_ready) begin
      if (state_reg == BUSY_I) begin
        i_data_reg <= mem_block_read_data;
      end else if (!op_write_reg) begin
        d_data_reg <= mem_block_read_data;
      end
    end
  end

  // Saturating wait counter, cleared on every grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else if (grant_any) begin
      wait_cnt_reg <= '0;
    end else if (busy && (wait_cnt_reg != CNT_MAX)) begin
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end
  end

  // Sticky timeout flag; the transaction keeps waiting after it is raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (busy && (wait_cnt_reg == CNT_MAX)) begin
      err_reg <= 1'b1;
    end
  end

  assign mem_address       = addr_reg;
  assign mem_write_data    = wdata_reg;
  assign i_block_read_data = i_data_reg;
  assign d_block_read_data = d_data_reg;
  assign err_timeout       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory
// commands and responses; a memory model and a ready monitor check them.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic         clk;
  logic         reset;
  logic         i_req;
  logic [31:0]  i_address;
  logic [127:0] i_block_read_data;
  logic         i_ready;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [63:0]  d_write_data;
  logic [127:0] d_block_read_data;
  logic         d_ready;
  logic [31:0]  mem_address;
  logic [63:0]  mem_write_data;
  logic         mem_read_out;
  logic         mem_write_out;
  logic [127:0] mem_block_read_data;
  logic         mem_ready;
  logic         err_timeout;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_req               (i_req),
    .i_address           (i_address),
    .i_block_read_data   (i_block_read_data),
    .i_ready             (i_ready),
    .d_read              (d_read),
    .d_write             (d_write),
    .d_address           (d_address),
    .d_write_data        (d_write_data),
    .d_block_read_data   (d_block_read_data),
    .d_ready             (d_ready),
    .mem_address         (mem_address),
    .mem_write_data      (mem_write_data),
    .mem_read_out        (mem_read_out),
    .mem_write_out       (mem_write_out),
    .mem_block_read_data (mem_block_read_data),
    .mem_ready           (mem_ready),
    .err_timeout         (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [63:0]  wdata;
    logic         wr;
    logic [127:0] rdata;
  } cmd_t;

  typedef struct {
    logic         side;   // 0 = I, 1 = D
    logic [127:0] data;
  } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];

  int checks = 0;
  int errors = 0;
  int mem_lat = 3;
  bit abort_txn = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [63:0] w, input logic wr, input logic [127:0] rd);
    cmd_t c;
    c.addr = a; c.wdata = w; c.wr = wr; c.rdata = rd;
    cmd_q.push_back(c);
  endtask

  task automatic push_resp(input logic side, input logic [127:0] data);
    resp_t r;
    r.side = side; r.data = data;
    resp_q.push_back(r);
  endtask

  // Bounded wait for the given side's ready pulse, observed on a falling edge.
  task automatic wait_ready(input logic side, input string name);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if ((side ? d_ready : i_ready) === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s no ready within 200 cycles", name);
    end
  endtask

  // Bounded wait until a memory strobe is up.
  task automatic wait_strobe(input string name);
    int n = 0;
    while (!(mem_read_out || mem_write_out) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(mem_read_out || mem_write_out)) begin
      errors++;
      $display("FAIL %s no memory strobe within 50 cycles", name);
    end
  endtask

  // Memory model: checks each command against the queue and answers after mem_lat cycles.
  initial begin
    int   busy_cycles = 0;
    cmd_t cur;
    mem_ready = 1'b0;
    mem_block_read_data = '0;
    cur.addr = '0; cur.wdata = '0; cur.wr = 1'b0; cur.rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read_out || mem_write_out) begin
        busy_cycles++;
        check("strobe_excl", 128'(mem_read_out & mem_write_out), 128'd0);
        if (busy_cycles == 1) begin
          if (cmd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cmd_unexpected addr=%h rd=%b wr=%b expected no command", mem_address, mem_read_out, mem_write_out);
          end else begin
            cur = cmd_q.pop_front();
            $display("cmd  addr=%h wr=%b wdata=%h", mem_address, mem_write_out, mem_write_data);
          end
          if (cur.wr) check("cmd_wdata", 128'(mem_write_data), 128'(cur.wdata));
        end
        check("cmd_addr", 128'(mem_address), 128'(cur.addr));
        check("cmd_write", 128'(mem_write_out), 128'(cur.wr));
        check("cmd_read", 128'(mem_read_out), 128'(!cur.wr));
        if (busy_cycles == mem_lat) begin
          mem_ready = 1'b1;
          mem_block_read_data = cur.rdata;
        end else begin
          mem_ready = 1'b0;
          mem_block_read_data = ~cur.rdata;
        end
      end else begin
        if (busy_cycles > 0 && !abort_txn) check("strobe_cycles", 128'(busy_cycles), 128'(mem_lat));
        busy_cycles = 0;
        mem_ready = 1'b0;
      end
    end
  end

  // Response monitor: pops the expected response whenever a ready pulse appears.
  initial begin
    logic  prev_rdy = 1'b0;
    resp_t e;
    forever begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        check("ready_excl", 128'(i_ready & d_ready), 128'd0);
        check("ready_pulse", 128'(prev_rdy), 128'd0);
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ready_unexpected i_ready=%b d_ready=%b expected none", i_ready, d_ready);
        end else begin
          e = resp_q.pop_front();
          $display("resp side=%s data=%h", d_ready ? "D" : "I", d_ready ? d_block_read_data : i_block_read_data);
          check("ready_side", 128'(d_ready), 128'(e.side));
          check("ready_data", d_ready ? d_block_read_data : i_block_read_data, e.data);
        end
      end
      prev_rdy = i_ready | d_ready;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},    128'(mem_read_out),  128'd0);
    check({tag, "_wr"},    128'(mem_write_out), 128'd0);
    check({tag, "_irdy"},  128'(i_ready),       128'd0);
    check({tag, "_drdy"},  128'(d_ready),       128'd0);
    check({tag, "_err"},   128'(err_timeout),   128'd0);
    check({tag, "_addr"},  128'(mem_address),   128'd0);
    check({tag, "_wdata"}, 128'(mem_write_data), 128'd0);
    check({tag, "_idata"}, i_block_read_data,   128'd0);
    check({tag, "_ddata"}, d_block_read_data,   128'd0);
  endtask

  // Directed stimulus.
  initial begin
    reset = 1'b1; i_req = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Tie right after reset: D, I, D, I while both sides keep requesting.
    push_cmd(32'h200, 64'd0, 1'b0, {4{32'h11111111}}); push_resp(1'b1, {4{32'h11111111}});
    push_cmd(32'h300, 64'd0, 1'b0, {4{32'h22222222}}); push_resp(1'b0, {4{32'h22222222}});
    push_cmd(32'h240, 64'd0, 1'b0, {4{32'h33333333}}); push_resp(1'b1, {4{32'h33333333}});
    push_cmd(32'h340, 64'd0, 1'b0, {4{32'h44444444}}); push_resp(1'b0, {4{32'h44444444}});
    @(posedge clk); #1;
    i_req = 1; i_address = 32'h300; d_read = 1; d_address = 32'h200;
    wait_ready(1'b1, "tie0_d"); d_read = 0;
    @(posedge clk); #1 d_read = 1; d_address = 32'h240;
    wait_ready(1'b0, "tie1_i"); i_req = 0;
    @(posedge clk); #1 i_req = 1; i_address = 32'h340;
    wait_ready(1'b1, "tie2_d"); d_read = 0;
    wait_ready(1'b0, "tie3_i"); i_req = 0;

    // I-only read of 0x40, memory answers after 3 cycles.
    push_cmd(32'h40, 64'd0, 1'b0, {16{8'hA5}}); push_resp(1'b0, {16{8'hA5}});
    @(posedge clk); #1 i_req = 1; i_address = 32'h40;
    wait_ready(1'b0, "iread40"); i_req = 0;
    check("iread40_err", 128'(err_timeout), 128'd0);

    // D write: completion returns the last D block unchanged.
    push_cmd(32'h100, 64'hDEADBEEF, 1'b1, {4{32'hBADBAD00}}); push_resp(1'b1, {4{32'h33333333}});
    @(posedge clk); #1 d_write = 1; d_address = 32'h100; d_write_data = 64'hDEADBEEF;
    wait_ready(1'b1, "dwrite"); d_write = 0;

    // d_read and d_write together: the write is issued.
    push_cmd(32'h180, 64'h0123456789ABCDEF, 1'b1, {4{32'hBADBAD01}}); push_resp(1'b1, {4{32'h33333333}});
    @(posedge clk); #1 d_read = 1; d_write = 1; d_address = 32'h180; d_write_data = 64'h0123456789ABCDEF;
    wait_ready(1'b1, "drw_both"); d_read = 0; d_write = 0;
    check("pre_timeout_err", 128'(err_timeout), 128'd0);

    // Slow memory: timeout flag rises while waiting, transaction still completes.
    mem_lat = TO + 6;
    push_cmd(32'h500, 64'd0, 1'b0, {4{32'h55555555}}); push_resp(1'b0, {4{32'h55555555}});
    @(posedge clk); #1 i_req = 1; i_address = 32'h500;
    wait_strobe("timeout_start");
    check("timeout_early_err", 128'(err_timeout), 128'd0);
    repeat (TO + 3) @(negedge clk);
    check("timeout_err_set", 128'(err_timeout), 128'd1);
    wait_ready(1'b0, "timeout_done"); i_req = 0;
    repeat (2) @(negedge clk);
    check("timeout_err_sticky", 128'(err_timeout), 128'd1);

    // Reset in the middle of a D read: abandoned, no response.
    mem_lat = 50;
    push_cmd(32'h600, 64'd0, 1'b0, {4{32'h66666666}});
    @(posedge clk); #1 d_read = 1; d_address = 32'h600;
    wait_strobe("abort_start");
    repeat (2) @(negedge clk);
    @(posedge clk); #1 abort_txn = 1; reset = 1; d_read = 0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1 reset = 0;
    repeat (3) @(negedge clk);
    abort_txn = 0;

    // A normal I read after the abandoned transaction.
    mem_lat = 3;
    push_cmd(32'h700, 64'd0, 1'b0, {4{32'h77777777}}); push_resp(1'b0, {4{32'h77777777}});
    @(posedge clk); #1 i_req = 1; i_address = 32'h700;
    wait_ready(1'b0, "post_reset_i"); i_req = 0;
    repeat (4) @(negedge clk);
    check("post_reset_err", 128'(err_timeout), 128'd0);
    check("resp_q_empty", 128'(resp_q.size()), 128'd0);
    check("cmd_q_empty", 128'(cmd_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
